// File: rtl/float_sub.sv
// float_sub: multi-cycle IEEE-754 single-precision subtractor (out = a - b), truncating, 5-state FSM.
// Define FLOAT_SUB_SPECIAL_EN for Inf/NaN handling; otherwise exponent 255 is ordinary and overflow saturates.
module float_sub (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, PACK} state_t;
  state_t state, state_nxt;

  logic [31:0]       op_a, op_b;
  logic [23:0]       big_man, sml_man;
  logic [7:0]        al_exp;
  logic              al_sign, al_sub;
  logic [24:0]       sum;
  logic [22:0]       nm_man;
  logic signed [9:0] nm_exp;
  logic              nm_zero;
`ifdef FLOAT_SUB_SPECIAL_EN
  logic              sp_hit;
  logic [31:0]       sp_val;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ALIGN;
      ALIGN:   state_nxt = SUB;
      SUB:     state_nxt = NORM;
      NORM:    state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Operand unpack and alignment; exponent 0 (zero/denormal) contributes a zero mantissa.
  logic        sa, sb, a_big;
  logic [7:0]  ea, eb, diff;
  logic [23:0] ma, mb, sm_raw, sm_shift;
  always_comb begin
    sa       = op_a[31];
    sb       = ~op_b[31];
    ea       = op_a[30:23];
    eb       = op_b[30:23];
    ma       = (ea == 8'd0) ? 24'd0 : {1'b1, op_a[22:0]};
    mb       = (eb == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};
    a_big    = {ea, ma} >= {eb, mb};
    diff     = a_big ? (ea - eb) : (eb - ea);
    sm_raw   = a_big ? mb : ma;
    sm_shift = (diff >= 8'd24) ? 24'd0 : (sm_raw >> diff);
  end

`ifdef FLOAT_SUB_SPECIAL_EN
  logic        nan_in, inf_a, inf_b;
  logic [31:0] sp_res;
  always_comb begin
    inf_a  = (ea == 8'hFF) && (op_a[22:0] == 23'd0);
    inf_b  = (eb == 8'hFF) && (op_b[22:0] == 23'd0);
    nan_in = ((ea == 8'hFF) && (op_a[22:0] != 23'd0)) ||
             ((eb == 8'hFF) && (op_b[22:0] != 23'd0));
    if (nan_in || (inf_a && inf_b && (sa != sb))) sp_res = 32'h7FC00000;
    else if (inf_a)                               sp_res = {sa, 8'hFF, 23'd0};
    else                                          sp_res = {sb, 8'hFF, 23'd0};
  end
`endif

  // Leading-zero count over the non-carry part of the sum, for the single-cycle left normalise.
  logic [4:0]  lz;
  logic        lz_found;
  logic [22:0] shifted;
  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!lz_found && sum[i]) begin
        lz       = 5'(23 - i);
        lz_found = 1'b1;
      end
    end
    shifted = 23'(sum[23:0] << lz);
  end

  logic [31:0] res;
  always_comb begin
    if (nm_zero)                res = 32'h0;
    else if (nm_exp <= 10'sd0)  res = {al_sign, 31'd0};
`ifdef FLOAT_SUB_SPECIAL_EN
    else if (nm_exp >= 10'sd255) res = {al_sign, 8'hFF, 23'd0};
`else
    else if (nm_exp >= 10'sd255) res = {al_sign, 8'hFE, 23'h7FFFFF};
`endif
    else                        res = {al_sign, nm_exp[7:0], nm_man};
`ifdef FLOAT_SUB_SPECIAL_EN
    if (sp_hit) res = sp_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      big_man <= 24'd0;
      sml_man <= 24'd0;
      al_exp  <= 8'd0;
      al_sign <= 1'b0;
      al_sub  <= 1'b0;
      sum     <= 25'd0;
      nm_man  <= 23'd0;
      nm_exp  <= 10'sd0;
      nm_zero <= 1'b0;
      out     <= 32'd0;
      done    <= 1'b0;
`ifdef FLOAT_SUB_SPECIAL_EN
      sp_hit  <= 1'b0;
      sp_val  <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_a <= a;
          op_b <= b;
        end
        ALIGN: begin
          big_man <= a_big ? ma : mb;
          sml_man <= sm_shift;
          al_exp  <= a_big ? ea : eb;
          al_sign <= a_big ? sa : sb;
          al_sub  <= sa ^ sb;
`ifdef FLOAT_SUB_SPECIAL_EN
          sp_hit  <= nan_in | inf_a | inf_b;
          sp_val  <= sp_res;
`endif
        end
        SUB: sum <= al_sub ? ({1'b0, big_man} - {1'b0, sml_man})
                           : ({1'b0, big_man} + {1'b0, sml_man});
        NORM: begin
          nm_zero <= (sum == 25'd0);
          if (sum[24]) begin
            nm_man <= sum[23:1];
            nm_exp <= $signed({2'b00, al_exp}) + 10'sd1;
          end else begin
            nm_man <= shifted;
            nm_exp <= $signed({2'b00, al_exp}) - $signed({5'd0, lz});
          end
        end
        PACK: begin
          out  <= res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_float_sub.sv
// tb_float_sub: self-checking bench for float_sub; directed cases plus random operands
// checked against an integer-arithmetic reference of a - b with truncation.
module tb_float_sub;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b, out;
  logic        busy, done;
  int n_checks = 0;
  int n_fail   = 0;

  float_sub dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                 .out(out), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, ebig, esml, d, e;
    longint mx, my, mbig, msml, r;
    bit sx, sy, sg;
    logic [7:0]  e8;
    logic [22:0] f;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    sy = !y[31];
    mx = (ex == 0) ? 0 : longint'({1'b1, x[22:0]});
    my = (ey == 0) ? 0 : longint'({1'b1, y[22:0]});
`ifdef FLOAT_SUB_SPECIAL_EN
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC00000;
    if (ex == 255 && ey == 255) return (sx == sy) ? {sx, 8'hFF, 23'd0} : 32'h7FC00000;
    if (ex == 255) return {sx, 8'hFF, 23'd0};
    if (ey == 255) return {sy, 8'hFF, 23'd0};
`endif
    if (ex > ey || (ex == ey && mx >= my)) begin
      ebig = ex; esml = ey; mbig = mx; msml = my; sg = sx;
    end else begin
      ebig = ey; esml = ex; mbig = my; msml = mx; sg = sy;
    end
    d    = ebig - esml;
    msml = (d >= 24) ? 0 : msml / (longint'(1) << d);
    r    = (sx == sy) ? mbig + msml : mbig - msml;
    if (r == 0) return 32'h0;
    e = ebig;
    while (r >= 64'd16777216) begin r = r / 2; e++; end
    while (r < 64'd8388608)   begin r = r * 2; e--; end
    if (e <= 0) return {sg, 31'd0};
`ifdef FLOAT_SUB_SPECIAL_EN
    if (e >= 255) return {sg, 8'hFF, 23'd0};
`else
    if (e >= 255) return {sg, 8'hFE, 23'h7FFFFF};
`endif
    e8 = e[7:0];
    f  = r[22:0];
    return {sg, e8, f};
  endfunction

  // Drive one operation; returns result, edges from acceptance to done (99 on timeout), busy cycles.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat, output int bcnt);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 99; bcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (busy) bcnt++;
      @(posedge clk);
    end
    r = out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 32'h3F800000; b = 32'h40000000;
    repeat (2) @(negedge clk);
    n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL reset_out got %h want 00000000", out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [31:0] r; int lat, bc;
    logic [31:0] xs[8] = '{32'h41200000, 32'h40A00000, 32'h3F800000, 32'h40490FDB,
                           32'h3F800000, 32'h00800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] ys[8] = '{32'h40A00000, 32'h41200000, 32'hBF800000, 32'h40490FDB,
                           32'h00400000, 32'h00800001, 32'h33800000, 32'h33000000};
    logic [31:0] ws[8] = '{32'h40A00000, 32'hC0A00000, 32'h40000000, 32'h00000000,
                           32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000};
    for (int i = 0; i < 8; i++) begin
      do_op(xs[i], ys[i], r, lat, bc);
      n_checks++; if (r !== ws[i]) begin n_fail++; $display("FAIL directed%0d got %h want %h", i, r, ws[i]); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL directed%0d_latency got %0d want 4", i, lat); end
      n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL directed%0d_busy got %0d want 4", i, bc); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, extra;
    logic [31:0] w;
    w = 32'h40A00000;
    @(negedge clk); a = 32'h41200000; b = 32'h40A00000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); a = 32'h3F800000; b = 32'hC2C80000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 99;
    for (int k = 2; k < 12; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      @(posedge clk);
    end
    n_checks++; if (out !== w) begin n_fail++; $display("FAIL busy_ignore_out got %h want %h", out, w); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL busy_ignore_latency got %0d want 4", lat); end
    extra = 0;
    repeat (8) begin @(negedge clk); if (done) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_ignore_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    logic [31:0] x1, y1, x2, y2;
    x1 = 32'h42F60000; y1 = 32'h41A80000; x2 = 32'hC1100000; y2 = 32'h3E800000;
    @(negedge clk); a = x1; b = y1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 99;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      @(posedge clk);
    end
    n_checks++; if (out !== ref_sub(x1, y1)) begin n_fail++; $display("FAIL b2b_first got %h want %h", out, ref_sub(x1, y1)); end
    a = x2; b = y2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; a = 32'h0; b = 32'h0;
    gap = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      gap++;
    end
    n_checks++; if (gap !== 5) begin n_fail++; $display("FAIL b2b_gap got %0d want 5", gap); end
    n_checks++; if (out !== ref_sub(x2, y2)) begin n_fail++; $display("FAIL b2b_second got %h want %h", out, ref_sub(x2, y2)); end
  endtask

  task automatic test_reset_abort();
    int extra;
    @(negedge clk); a = 32'h41200000; b = 32'h3F800000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL abort_out got %h want 00000000", out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    extra = 0;
    repeat (8) begin @(negedge clk); if (done) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", extra); end
  endtask

  task automatic test_config();
    logic [31:0] r; int lat, bc;
`ifdef FLOAT_SUB_SPECIAL_EN
    do_op(32'h7F800000, 32'h3F800000, r, lat, bc);
    n_checks++; if (r !== 32'h7F800000) begin n_fail++; $display("FAIL inf_minus_one got %h want 7f800000", r); end
    do_op(32'h7F800000, 32'h7F800000, r, lat, bc);
    n_checks++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL inf_minus_inf got %h want 7fc00000", r); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL special_latency got %0d want 4", lat); end
`else
    do_op(32'h7F7FFFFF, 32'hFF7FFFFF, r, lat, bc);
    n_checks++; if (r !== 32'h7F7FFFFF) begin n_fail++; $display("FAIL overflow_sat got %h want 7f7fffff", r); end
    do_op(32'hFF7FFFFF, 32'h7F7FFFFF, r, lat, bc);
    n_checks++; if (r !== 32'hFF7FFFFF) begin n_fail++; $display("FAIL overflow_sat_neg got %h want ff7fffff", r); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] x, y, r, w; int lat, bc, ex, ey, mode;
    for (int i = 0; i < 60; i++) begin
      ex   = $urandom_range(0, 255);
      mode = $urandom_range(0, 5);
      case (mode)
        0:       ey = ex;
        1:       ey = ex + $urandom_range(0, 60) - 30;
        2:       ey = 0;
        default: ey = $urandom_range(0, 255);
      endcase
      if (ey < 0) ey = 0;
      if (ey > 255) ey = 255;
      x = {1'($urandom), 8'(ex), 23'($urandom)};
      y = {1'($urandom), 8'(ey), 23'($urandom)};
      if (mode == 3) y = {1'($urandom), x[30:0]};
      w = ref_sub(x, y);
      do_op(x, y, r, lat, bc);
      n_checks++; if (r !== w) begin n_fail++; $display("FAIL random%0d a=%h b=%h got %h want %h", i, x, y, r, w); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL random%0d_latency got %0d want 4", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_config();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
